dmem_ctrl: RTL and testbench

- Parametrised data-memory controller. Successor of the single-cycle combinational data memory.
- Serves one load/store port from the CPU core using a valid/ready request and response handshake.
- Hits in a local byte-maskable scratchpad (DEPTH words) complete with fixed 1-cycle latency.
- Misses are forwarded to an external bus port with req/ack handshake and a timeout, replacing direct DPI access at this level.

---
 rtl/dmem_ctrl_if.sv | 42 ++++
 rtl/dmem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Core load/store port plus external bus port of the data-memory controller.
// Both handshakes move data on a clock edge where valid and ready are both high.
interface dmem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  logic                  ext_valid;
  logic                  ext_ready;
  logic                  ext_we;
  logic [ADDR_W-1:0]     ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic [DATA_W/8-1:0]   ext_wmask;
  logic                  ext_rvalid;
  logic [DATA_W-1:0]     ext_rdata;
  logic                  ext_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
           ext_ready, ext_rvalid, ext_rdata, ext_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           ext_valid, ext_we, ext_addr, ext_wdata, ext_wmask
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
           ext_ready, ext_rvalid, ext_rdata, ext_err,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           ext_valid, ext_we, ext_addr, ext_wdata, ext_wmask
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one outstanding load/store, served from a local
// byte-maskable scratchpad on a hit or forwarded to the external bus on a miss.
module dmem_ctrl #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
  parameter int                DEPTH   = 256,
  parameter int                TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus,
  output logic [2:0]  dbg_state_o
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 16;

  localparam logic [ADDR_W:0]   SPAN       = (ADDR_W+1)'(DEPTH * BYTES);
  localparam logic [ADDR_W:0]   HIT_LO     = {1'b0, BASE};
  localparam logic [ADDR_W:0]   HIT_HI     = HIT_LO + SPAN - (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOCAL    = 3'd1,
    EXT_REQ  = 3'd2,
    EXT_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [BYTES-1:0]   wmask_q;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  rd_q;

  logic               accept;
  logic               hit;
  logic               misaligned;
  logic               timeout_hit;
  logic [ADDR_W:0]    addr_x;
  logic [IDX_W-1:0]   idx;

  // Widened by one bit so BASE+SPAN cannot wrap at the top of the address space.
  assign addr_x      = {1'b0, bus.req_addr};
  assign hit         = (addr_x >= HIT_LO) && (addr_x <= HIT_HI);
  assign misaligned  = |(bus.req_addr & ALIGN_MASK);
  // BASE is aligned to the scratchpad span, so the raw address bits are the index.
  assign idx         = bus.req_addr[OFF_W +: IDX_W];
  assign accept      = bus.req_valid && bus.req_ready;
  assign timeout_hit = (cnt_q == CNT_LAST);

  // Stores commit at the accept edge; the read port samples the same edge.
  always_ff @(posedge clk) begin
    if (accept && hit && !misaligned) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.req_we && bus.req_wmask[b]) begin
          mem[idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
        end
      end
      rd_q <= mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      wmask_q <= bus.req_wmask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (misaligned) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (hit) begin
            state_d = LOCAL;
          end else begin
            state_d = EXT_REQ;
          end
        end
      end
      LOCAL: begin
        state_d = RESP;
        rdata_d = we_q ? '0 : rd_q;
        err_d   = 1'b0;
      end
      EXT_REQ, EXT_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Timeout wins over a handshake or completion in the same cycle.
        if (timeout_hit) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (state_q == EXT_REQ) begin
          if (bus.ext_ready) state_d = EXT_WAIT;
        end else if (bus.ext_rvalid) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : bus.ext_rdata;
          err_d   = bus.ext_err;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = rst_n && (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.ext_valid = (state_q == EXT_REQ);
  assign bus.ext_we    = we_q;
  assign bus.ext_addr  = addr_q;
  assign bus.ext_wdata = wdata_q;
  assign bus.ext_wmask = wmask_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: scratchpad hits, misses, timeout, misalignment
// and reset behaviour, with hand-computed expected values.
module tb_dmem_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  dmem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  dmem_ctrl #(
    .DATA_W (32),
    .ADDR_W (32),
    .BASE   (32'h8000_0000),
    .DEPTH  (256),
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // Hit table: store/load sequence with expected response data.
  logic        ht_we   [11] = '{1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0};
  logic [31:0] ht_addr [11] = '{32'h8000_0010, 32'h8000_0010, 32'h8000_0010, 32'h8000_0010,
                                32'h8000_0010, 32'h8000_0010, 32'h8000_0010, 32'h8000_03FC,
                                32'h8000_03FC, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] ht_wdata[11] = '{32'hDEAD_BEEF, 32'h0, 32'h0000_00AA, 32'h0000_BB00, 32'h0,
                                32'hFFFF_FFFF, 32'h0, 32'h5A5A_A5A5, 32'h0, 32'h0123_4567, 32'h0};
  logic [3:0]  ht_wmask[11] = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
  logic [31:0] ht_exp  [11] = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hDEAD_BBAA, 32'h0,
                                32'hDEAD_BBAA, 32'h0, 32'h5A5A_A5A5, 32'h0, 32'h0123_4567};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wmask  = '0;
    bus.rsp_ready  = 1'b1;
    bus.ext_ready  = 1'b0;
    bus.ext_rvalid = 1'b0;
    bus.ext_rdata  = '0;
    bus.ext_err    = 1'b0;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    drive_idle();
    #1 rst_n = 1'b0;
    #2;
    n_tests++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ext_valid,
         bus.ext_we, bus.ext_addr, bus.ext_wdata, bus.ext_wmask, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req_ready=%0b rsp_valid=%0b ext_valid=%0b state=%0d, all required 0",
               bus.req_ready, bus.rsp_valid, bus.ext_valid, dbg_state);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %0b want 1", bus.req_ready);
    end
  endtask

  task automatic test_local_hits;
    for (int i = 0; i < 11; i++) begin
      drive_req(ht_we[i], ht_addr[i], ht_wdata[i], ht_wmask[i]);
      tick();
      bus.req_valid = 1'b0;
      n_tests++;
      if ({bus.rsp_valid, bus.ext_valid, bus.req_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL hit%0d_local: rsp_valid=%0b ext_valid=%0b req_ready=%0b want 0/0/0",
                 i, bus.rsp_valid, bus.ext_valid, bus.req_ready);
      end
      tick();
      n_tests++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, ht_exp[i]}) begin
        n_fail++;
        $display("FAIL hit%0d_rsp: valid=%0b err=%0b rdata=%h want 1/0/%h",
                 i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, ht_exp[i]);
      end
      tick();
      n_tests++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
        n_fail++;
        $display("FAIL hit%0d_clear: valid=%0b err=%0b rdata=%h ready=%0b want 0/0/0/1",
                 i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n_rsp;
    n_rsp = 0;
    drive_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    for (int c = 0; c < 9; c++) begin
      tick();
      if (bus.rsp_valid === 1'b1) begin
        n_rsp++;
        n_tests++;
        if (bus.rsp_rdata !== 32'hDEAD_BBAA) begin
          n_fail++;
          $display("FAIL b2b_rdata: got %h want deadbbaa", bus.rsp_rdata);
        end
      end
    end
    bus.req_valid = 1'b0;
    n_tests++;
    if (n_rsp !== 3) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d responses in 9 cycles want 3", n_rsp);
    end
  endtask

  task automatic test_misaligned;
    drive_req(1'b0, 32'h8000_0002, 32'h0, 4'h0);
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL misalign_rsp: valid=%0b err=%0b rdata=%h want 1/1/0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready, bus.ext_valid} !==
          {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL misalign_hold%0d: valid=%0b err=%0b rdata=%h ready=%0b ext=%0b want 1/1/0/0/0",
                 c, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready, bus.ext_valid);
      end
    end
    bus.rsp_ready = 1'b1;
    tick();
    // A misaligned store must leave the scratchpad untouched.
    drive_req(1'b1, 32'h8000_0012, 32'h0000_0000, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_err, bus.ext_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL misalign_store: valid=%0b err=%0b ext=%0b want 1/1/0",
               bus.rsp_valid, bus.rsp_err, bus.ext_valid);
    end
    tick();
    drive_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'hDEAD_BBAA}) begin
      n_fail++;
      $display("FAIL misalign_nowrite: valid=%0b err=%0b rdata=%h want 1/0/deadbbaa",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_miss_load;
    drive_req(1'b0, 32'h8000_0400, 32'h0, 4'h0);
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({bus.ext_valid, bus.ext_we, bus.ext_addr, bus.rsp_valid} !== {1'b1, 1'b0, 32'h8000_0400, 1'b0}) begin
        n_fail++;
        $display("FAIL miss_req%0d: ext_valid=%0b we=%0b addr=%h rsp_valid=%0b want 1/0/80000400/0",
                 k, bus.ext_valid, bus.ext_we, bus.ext_addr, bus.rsp_valid);
      end
      if (k < 2) tick();
    end
    bus.ext_ready = 1'b1;
    tick();
    bus.ext_ready = 1'b0;
    n_tests++;
    if ({bus.ext_valid, bus.rsp_valid, dbg_state} !== {1'b0, 1'b0, 3'd3}) begin
      n_fail++;
      $display("FAIL miss_wait: ext_valid=%0b rsp_valid=%0b state=%0d want 0/0/3",
               bus.ext_valid, bus.rsp_valid, dbg_state);
    end
    tick();
    bus.ext_rvalid = 1'b1;
    bus.ext_rdata  = 32'h1234_5678;
    tick();
    bus.ext_rvalid = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL miss_rsp: valid=%0b err=%0b rdata=%h want 1/0/12345678",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_miss_store_err;
    drive_req(1'b1, 32'h0000_0100, 32'h1122_3344, 4'h3);
    tick();
    bus.req_valid = 1'b0;
    n_tests++;
    if ({bus.ext_valid, bus.ext_we, bus.ext_addr, bus.ext_wdata, bus.ext_wmask} !==
        {1'b1, 1'b1, 32'h0000_0100, 32'h1122_3344, 4'h3}) begin
      n_fail++;
      $display("FAIL store_ext_fields: valid=%0b we=%0b addr=%h wdata=%h wmask=%h want 1/1/00000100/11223344/3",
               bus.ext_valid, bus.ext_we, bus.ext_addr, bus.ext_wdata, bus.ext_wmask);
    end
    bus.ext_ready = 1'b1;
    tick();
    bus.ext_ready  = 1'b0;
    bus.ext_rvalid = 1'b1;
    bus.ext_err    = 1'b1;
    bus.ext_rdata  = 32'hFFFF_FFFF;
    tick();
    bus.ext_rvalid = 1'b0;
    bus.ext_err    = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL store_ext_err: valid=%0b err=%0b rdata=%h want 1/1/0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_timeout;
    drive_req(1'b0, 32'h9000_0000, 32'h0, 4'h0);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) bus.ext_ready = 1'b1;
      tick();
      n_tests++;
      if (i < 8) begin
        if ({bus.ext_valid, bus.rsp_valid} !== 2'b10) begin
          n_fail++;
          $display("FAIL timeout_pending%0d: ext_valid=%0b rsp_valid=%0b want 1/0",
                   i, bus.ext_valid, bus.rsp_valid);
        end
      end else if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ext_valid} !==
                   {1'b1, 1'b1, 32'h0, 1'b0}) begin
        n_fail++;
        $display("FAIL timeout_rsp: valid=%0b err=%0b rdata=%h ext_valid=%0b want 1/1/0/0",
                 bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ext_valid);
      end
    end
    bus.ext_ready = 1'b0;
    tick();
    bus.ext_rvalid = 1'b1;
    bus.ext_rdata  = 32'hCAFE_F00D;
    tick();
    bus.ext_rvalid = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, dbg_state, bus.req_ready} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_late_rvalid: rsp_valid=%0b state=%0d ready=%0b want 0/0/1",
               bus.rsp_valid, dbg_state, bus.req_ready);
    end
    drive_req(1'b0, 32'h9000_0000, 32'h0, 4'h0);
    bus.ext_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.ext_ready  = 1'b0;
    bus.ext_rvalid = 1'b1;
    bus.ext_rdata  = 32'h0BAD_F00D;
    tick();
    bus.ext_rvalid = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
      n_fail++;
      $display("FAIL timeout_next_req: valid=%0b err=%0b rdata=%h want 1/0/0badf00d",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    drive_req(1'b0, 32'h9000_0000, 32'h0, 4'h0);
    bus.ext_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.ext_ready = 1'b0;
    n_tests++;
    if (dbg_state !== 3'd3) begin
      n_fail++;
      $display("FAIL rstmid_in_wait: state=%0d want 3", dbg_state);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ext_valid,
         bus.ext_we, bus.ext_addr, bus.ext_wdata, bus.ext_wmask, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: ready=%0b rsp_valid=%0b ext_valid=%0b ext_addr=%h state=%0d want all 0",
               bus.req_ready, bus.rsp_valid, bus.ext_valid, bus.ext_addr, dbg_state);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready: got %0b want 1", bus.req_ready);
    end
    bus.ext_rvalid = 1'b1;
    bus.ext_rdata  = 32'h5555_5555;
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.ext_rvalid = 1'b0;
      n_tests++;
      if ({bus.rsp_valid, dbg_state} !== {1'b0, 3'd0}) begin
        n_fail++;
        $display("FAIL rstmid_stale%0d: rsp_valid=%0b state=%0d want 0/0", c, bus.rsp_valid, dbg_state);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_local_hits();
    test_back_to_back();
    test_misaligned();
    test_miss_load();
    test_miss_store_err();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
